// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit counters sharing one command port.
// Each counter can hold, load, increment or decrement, in wrap or saturate mode,
// and keeps a sticky overflow flag. A combinational offset read of the selected
// channel feeds branch/loop targets to the datapath.
//
// Ports:
//   Clk     in   1                rising-edge clock
//   ResetN  in   1                asynchronous active-low reset
//   Sel     in   SelW             channel addressed by Op, Offset, ClrOvf and ValOut
//   Op      in   2                00 hold, 01 load ValIn, 10 increment, 11 decrement
//   ValIn   in   WIDTH            load value
//   Offset  in   2                read mode: 00 +0, 01 +OFF1, 10 +OFF2, 11 -OFF1
//   ClrAll  in   1                synchronous clear of every counter and overflow flag
//   ClrOvf  in   1                clear the overflow flag of channel Sel
//   ValOut  out  WIDTH            combinational read of channel Sel
//   Zero    out  CHANNELS         bit i = (counter i == 0)
//   Ovf     out  CHANNELS         sticky per-channel overflow flags
module counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int OFF1     = 30,
  parameter int OFF2     = 60,
  parameter int SATURATE = 0,
  localparam int SelW    = $clog2(CHANNELS)
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [SelW-1:0]   Sel,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  ValIn,
  input  logic [1:0]        Offset,
  input  logic              ClrAll,
  input  logic              ClrOvf,
  output logic [WIDTH-1:0]  ValOut,
  output logic [CHANNELS-1:0] Zero,
  output logic [CHANNELS-1:0] Ovf
);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b11;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  // Offsets reduced modulo 2^WIDTH; -OFF1 is the two's complement of OFF1.
  localparam logic [WIDTH-1:0] OFF1_W   = WIDTH'(OFF1);
  localparam logic [WIDTH-1:0] OFF2_W   = WIDTH'(OFF2);
  localparam logic [WIDTH-1:0] NOFF1_W  = ALL_ZERO - OFF1_W;

  logic [WIDTH-1:0] cnt_reg [CHANNELS];
  logic [CHANNELS-1:0] ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] cnt_next;
      logic             ovf_event;
      logic             hit;

      assign hit = (Sel == SelW'(gi));

      // Next value for this channel if it is the one addressed; also flags
      // a wrap/clamp event (never raised by a load).
      always_comb begin
        cnt_next  = cnt_reg[gi];
        ovf_event = 1'b0;
        case (Op)
          OP_LOAD: cnt_next = ValIn;
          OP_INC: begin
            if (cnt_reg[gi] == ALL_ONES) begin
              ovf_event = 1'b1;
              cnt_next  = (SATURATE != 0) ? ALL_ONES : ALL_ZERO;
            end else begin
              cnt_next = cnt_reg[gi] + ONE;
            end
          end
          OP_DEC: begin
            if (cnt_reg[gi] == ALL_ZERO) begin
              ovf_event = 1'b1;
              cnt_next  = (SATURATE != 0) ? ALL_ZERO : ALL_ONES;
            end else begin
              cnt_next = cnt_reg[gi] - ONE;
            end
          end
          default: cnt_next = cnt_reg[gi];
        endcase
      end

      always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
          cnt_reg[gi] <= ALL_ZERO;
          ovf_reg[gi] <= 1'b0;
        end else if (ClrAll) begin
          cnt_reg[gi] <= ALL_ZERO;
          ovf_reg[gi] <= 1'b0;
        end else if (hit) begin
          cnt_reg[gi] <= cnt_next;
          // A new overflow beats a simultaneous clear request.
          if (ovf_event) begin
            ovf_reg[gi] <= 1'b1;
          end else if (ClrOvf) begin
            ovf_reg[gi] <= 1'b0;
          end
        end
      end

      assign Zero[gi] = (cnt_reg[gi] == ALL_ZERO);
    end
  endgenerate

  assign Ovf = ovf_reg;

  // Read path sees the current register, never the pending write. During a
  // load the raw value is returned so the caller observes the old contents.
  logic [WIDTH-1:0] rd_raw;
  logic [WIDTH-1:0] rd_add;

  always_comb begin
    rd_raw = cnt_reg[Sel];
    case (Offset)
      2'b01:   rd_add = OFF1_W;
      2'b10:   rd_add = OFF2_W;
      2'b11:   rd_add = NOFF1_W;
      default: rd_add = ALL_ZERO;
    endcase
    ValOut = (Op == OP_LOAD) ? rd_raw : (rd_raw + rd_add);
  end

  logic unused_hold;
  assign unused_hold = (OP_HOLD == 2'b00);

endmodule

// File: tb/tb_counter_bank.sv
module tb_counter_bank;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int M  = 256;

  logic       Clk;
  logic       ResetN;
  logic [1:0] Sel;
  logic [1:0] Op;
  logic [7:0] ValIn;
  logic [1:0] Offset;
  logic       ClrAll;
  logic       ClrOvf;

  logic [7:0] val_w, val_s;
  logic [3:0] zero_w, zero_s, ovf_w, ovf_s;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  counter_bank #(.WIDTH(W), .CHANNELS(N), .OFF1(30), .OFF2(60), .SATURATE(0)) u_wrap (
    .Clk(Clk), .ResetN(ResetN), .Sel(Sel), .Op(Op), .ValIn(ValIn), .Offset(Offset),
    .ClrAll(ClrAll), .ClrOvf(ClrOvf), .ValOut(val_w), .Zero(zero_w), .Ovf(ovf_w));

  counter_bank #(.WIDTH(W), .CHANNELS(N), .OFF1(30), .OFF2(60), .SATURATE(1)) u_sat (
    .Clk(Clk), .ResetN(ResetN), .Sel(Sel), .Op(Op), .ValIn(ValIn), .Offset(Offset),
    .ClrAll(ClrAll), .ClrOvf(ClrOvf), .ValOut(val_s), .Zero(zero_s), .Ovf(ovf_s));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: index 0 = wrapping instance, 1 = saturating instance.
  int mc [2][N];
  bit mo [2][N];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++) begin mc[d][i] = 0; mo[d][i] = 0; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ClrAll) begin
          for (int i = 0; i < N; i++) begin mc[d][i] = 0; mo[d][i] = 0; end
        end else begin
          int s; int c; bit ev;
          s = Sel; c = mc[d][s]; ev = 0;
          case (Op)
            2'd1: c = ValIn;
            2'd2: if (c == M - 1) begin ev = 1; c = (d == 1) ? M - 1 : 0; end else c = c + 1;
            2'd3: if (c == 0) begin ev = 1; c = (d == 1) ? 0 : M - 1; end else c = c - 1;
            default: ;
          endcase
          mc[d][s] = c;
          if (ev) mo[d][s] = 1;
          else if (ClrOvf) mo[d][s] = 0;
        end
      end
    end
  end

  function automatic int exp_val(input int d);
    int offs [4] = '{0, 30, 60, M - 30};
    if (Op == 2'd1) return mc[d][Sel];
    return (mc[d][Sel] + offs[Offset]) % M;
  endfunction

  function automatic int exp_zero(input int d);
    int z = 0;
    for (int i = 0; i < N; i++) if (mc[d][i] == 0) z |= (1 << i);
    return z;
  endfunction

  function automatic int exp_ovf(input int d);
    int o = 0;
    for (int i = 0; i < N; i++) if (mo[d][i]) o |= (1 << i);
    return o;
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    if (check_en) begin
      chk("wrap_valout", val_w, exp_val(0));
      chk("wrap_zero", zero_w, exp_zero(0));
      chk("wrap_ovf", ovf_w, exp_ovf(0));
      chk("sat_valout", val_s, exp_val(1));
      chk("sat_zero", zero_s, exp_zero(1));
      chk("sat_ovf", ovf_s, exp_ovf(1));
    end
  end

  task automatic idle();
    Op = 2'd0; ClrAll = 1'b0; ClrOvf = 1'b0; Offset = 2'd0; ValIn = 8'd0;
  endtask

  // One clocked command; returns 1 ns after the edge with inputs idle.
  task automatic cyc(input int s, input int op, input int v, input int off,
                     input bit ca, input bit co);
    Sel = 2'(s); Op = 2'(op); ValIn = 8'(v); Offset = 2'(off); ClrAll = ca; ClrOvf = co;
    @(posedge Clk); #1;
    idle();
    $display("cmd sel=%0d op=%0d val=%0d off=%0d clrall=%0d clrovf=%0d -> zw=%b ow=%b zs=%b os=%b",
             s, op, v, off, ca, co, zero_w, ovf_w, zero_s, ovf_s);
  endtask

  initial begin
    ResetN = 1'b0; Sel = 2'd0; idle();
    check_en = 1'b1;
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;

    // Load and offset reads.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(2, 1, 200, 0, 0, 0);
    Sel = 2'd2; Offset = 2'd1; #1 chk("off_plus1", val_w, 230);
    Offset = 2'd2; #1 chk("off_plus2", val_w, 4);
    Offset = 2'd3; #1 chk("off_minus1", val_w, 170);
    Op = 2'd1; #1 chk("load_raw", val_w, 200);
    idle();

    // Wrap / clamp at all-ones on ch1.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 1, 255, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    chk("wrap_inc_zero", zero_w, 4'b1111);
    chk("wrap_inc_ovf", ovf_w, 4'b0010);
    chk("sat_inc_zero", zero_s, 4'b1101);
    chk("sat_inc_ovf", ovf_s, 4'b0010);

    // Clamp at zero on ch3, then clear its flag.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(3, 3, 0, 0, 0, 0);
    chk("sat_dec_ovf", ovf_s, 4'b1000);
    chk("sat_dec_zero", zero_s, 4'b1111);
    chk("wrap_dec_zero", zero_w, 4'b0111);
    Sel = 2'd3; #1 chk("wrap_dec_val", val_w, 255);
    cyc(3, 0, 0, 0, 0, 1);
    chk("sat_clrovf", ovf_s, 4'b0000);

    // Overflow beats ClrOvf; ClrAll beats a load.
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 255, 0, 0, 0);
    cyc(0, 2, 0, 0, 0, 1);
    chk("collide_ovf_w", ovf_w, 4'b0001);
    chk("collide_ovf_s", ovf_s, 4'b0001);
    cyc(0, 1, 9, 0, 1, 0);
    chk("clrall_zero", zero_w, 4'b1111);
    chk("clrall_ovf", ovf_s, 4'b0000);

    // Asynchronous reset mid-cycle with nonzero state.
    cyc(1, 1, 77, 0, 0, 0);
    cyc(2, 1, 0, 0, 0, 0);
    cyc(2, 3, 0, 0, 0, 0);
    #1 ResetN = 1'b0;
    #1 chk("rst_zero", zero_w, 4'b1111);
    chk("rst_ovf", ovf_w, 4'b0000);
    Sel = 2'd1; #0 chk("rst_val", val_w, 0);
    @(posedge Clk); #1 ResetN = 1'b1;

    // Randomised run against the model.
    for (int k = 0; k < 1000; k++) begin
      int s, op, v, off;
      bit ca, co;
      s   = $urandom_range(0, 3);
      op  = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = 255;
        default: v = $urandom_range(0, 255);
      endcase
      off = $urandom_range(0, 3);
      ca  = ($urandom_range(0, 63) == 0);
      co  = ($urandom_range(0, 7) == 0);
      Sel = 2'(s); Op = 2'(op); ValIn = 8'(v); Offset = 2'(off); ClrAll = ca; ClrOvf = co;
      @(negedge Clk);
      $display("rnd %0d sel=%0d op=%0d val=%0d off=%0d ca=%0d co=%0d vw=%0d vs=%0d",
               k, s, op, v, off, ca, co, val_w, val_s);
      @(posedge Clk); #1;
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
